fb_sram_reader: RTL
===================

# fb_sram_reader

Video-side bus initiator for the framebuffer SRAM. It arbitrates with the CPU for the shared SRAM bus through the 16-bit bus-switch mux, and drives the two switch enables with a break-before-make dead cycle. During each video tenure it issues asynchronous SRAM reads and streams the fetched bytes to the pixel shifter through a 2-entry FIFO with a valid/ready handshake. It reads one frame of bytes sequentially from a base address, and the CPU always has priority between accesses.

## Interface
- ADDR_W, 15, SRAM address width (32 KiB part)
- BASE_ADDR, 15'h0000, first framebuffer byte address
- FRAME_BYTES, 8000, bytes per frame (320x200, 1 bpp)
- WAIT_CYCLES, 1, extra cycles between address setup and data capture (0 allowed)
- clk  input  1  system clock; all state on rising edge
- rst  input  1  reset, synchronous, active-high
- frame_start  input  1  one-cycle pulse; starts a frame fetch
- cpu_req  input  1  CPU requests the SRAM bus
- cpu_gnt  output  1  CPU owns the bus (CPU side of the mux enabled)
- mux_oe1_n  output  1  bus-switch enable, CPU side, active-low
- mux_oe2_n  output  1  bus-switch enable, video side, active-low
- sram_addr  output  ADDR_W  read address
- sram_ce_n, sram_oe_n, sram_we_n  output  1 each  SRAM strobes, active-low
- sram_data_in  input  8  SRAM read data
- px_byte  output  8  FIFO head byte
- px_valid  output  1  px_byte is valid
- px_ready  input  1  consumer accepts px_byte when px_valid is high
- frame_done  output  1  one-cycle pulse after the last byte is captured

## Operation
- States:
  - CPU_OWN: oe1_n=0, oe2_n=1, cpu_gnt=1.
  - DEAD_TO_VID: both enables high, cpu_gnt=0.
  - VID_ADDR and VID_WAIT: oe2_n=0, ce_n=0, oe_n=0.
  - VID_CAPT: oe2_n=0, ce_n=0, oe_n=0.
  - DEAD_TO_CPU: both enables high.
- Reset values:
  - state CPU_OWN; cpu_gnt=1, mux_oe1_n=0, mux_oe2_n=1.
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_addr=0.
  - FIFO empty, px_valid=0, px_byte=0, frame_done=0.
  - active=0, byte counter=0.
- sram_we_n is constant 1.
- frame_start with active=0: active←1, counter←0. frame_start with active=1: ignored.
- slot_free: FIFO occupancy after this cycle's push/pop is less than 2.
- CPU_OWN → DEAD_TO_VID when active && slot_free && !cpu_req.
- DEAD_TO_VID → VID_ADDR.
- VID_ADDR → VID_WAIT, or → VID_CAPT when WAIT_CYCLES=0.
- VID_WAIT lasts WAIT_CYCLES cycles, then → VID_CAPT.
- VID_CAPT:
  - sram_data_in is pushed to the FIFO on the edge ending this state.
  - counter increments on the same edge.
  - Next state is VID_ADDR (back-to-back; strobes stay low) if active-after-capture && slot_free && !cpu_req.
  - Otherwise next state is DEAD_TO_CPU. Strobes deassert on entering DEAD_TO_CPU.
- DEAD_TO_CPU → CPU_OWN.
- sram_addr = (BASE_ADDR + counter) mod 2^ADDR_W. The address wraps past 0x7FFF to 0x0000. It is valid from VID_ADDR entry until capture.
- The capture of byte FRAME_BYTES-1 clears active and pulses frame_done in the following cycle.
- A started access is never aborted. cpu_req during VID_* is honoured only after the capture completes.
- FIFO pop: px_valid && px_ready. A simultaneous push and pop on a full FIFO is legal. The FIFO never overflows, because fetches are gated by slot_free.
- rst mid-access: all outputs return to reset values on the next edge; FIFO contents and the frame in progress are discarded.

## Timing
- Both mux enables are never low in the same cycle. Every ownership change inserts exactly 1 dead cycle.
- Example with WAIT_CYCLES=1, cpu_req=0, frame_start sampled at edge N:
  - DEAD_TO_VID at N+1, VID_ADDR at N+2, VID_WAIT at N+3, VID_CAPT at N+4.
  - The byte is sampled at N+5; px_valid=1 from N+5.
- Access period: 2+WAIT_CYCLES cycles per byte back-to-back.
- Return path: cpu_gnt rises 2 cycles after the last video capture edge (DEAD_TO_CPU, then CPU_OWN).
- FIFO latency: first-word latency is 0 beyond capture; px_byte is registered at the head.

## Test plan
- Reset and idle: assert rst 2 cycles, release → cpu_gnt=1, oe1_n=0, oe2_n=1, all SRAM strobes 1, px_valid=0, for 20 cycles with no frame_start.
- Basic fetch:
  - Setup: SRAM model preloaded with addr[7:0], BASE_ADDR=0x100, FRAME_BYTES=4, px_ready=1.
  - Stimulus: frame_start pulse.
  - Required: px_byte sequence 0x00,0x01,0x02,0x03; first px_valid 5 cycles after frame_start; frame_done exactly once; cpu_gnt returns to 1.
- Backpressure: px_ready=0 → exactly 2 bytes fetched, then bus returned to the CPU. Raising px_ready resumes fetching with the next address; no byte is lost or duplicated.
- CPU priority: raise cpu_req during VID_WAIT → the current byte completes, 1 dead cycle follows, then cpu_gnt=1. No video access occurs while cpu_req=1. Fetching resumes at the next address after cpu_req falls.
- Wrap and mutual exclusion:
  - Setup: BASE_ADDR=0x7FFE, FRAME_BYTES=4.
  - Required: addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001.
  - Assertion held throughout: never (mux_oe1_n==0 && mux_oe2_n==0).
- Reset mid-frame: rst during VID_CAPT → all outputs at reset values next cycle, FIFO empty, no frame_done. A fresh frame_start restarts from BASE_ADDR.

Source files
------------

// File: rtl/fb_sram_reader.sv
// Video-side initiator for the shared framebuffer SRAM: arbitrates the bus against
// the CPU through the bus-switch mux and streams one frame of bytes into a 2-entry FIFO.
module fb_sram_reader #(
    parameter int                ADDR_W      = 15,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                FRAME_BYTES = 8000,
    parameter int                WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              cpu_req,
    output logic              cpu_gnt,
    output logic              mux_oe1_n,
    output logic              mux_oe2_n,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    input  logic [7:0]        sram_data_in,
    output logic [7:0]        px_byte,
    output logic              px_valid,
    input  logic              px_ready,
    output logic              frame_done
);

    localparam logic [2:0] S_CPU_OWN     = 3'd0;
    localparam logic [2:0] S_DEAD_TO_VID = 3'd1;
    localparam logic [2:0] S_VID_ADDR    = 3'd2;
    localparam logic [2:0] S_VID_WAIT    = 3'd3;
    localparam logic [2:0] S_VID_CAPT    = 3'd4;
    localparam logic [2:0] S_DEAD_TO_CPU = 3'd5;

    localparam int CNT_W  = $clog2(FRAME_BYTES + 1);
    localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(FRAME_BYTES - 1);

    logic [2:0]        state_reg, state_next;
    logic              active_reg;
    logic [CNT_W-1:0]  byte_cnt_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [7:0]        head_reg, tail_reg;
    logic [1:0]        fifo_cnt_reg;
    logic              frame_done_reg;

    logic       push, pop, last_capt, slot_free, vid_own;
    logic [1:0] fifo_cnt_after;

    assign push           = (state_reg == S_VID_CAPT);
    assign pop            = (fifo_cnt_reg != 2'd0) && px_ready;
    assign fifo_cnt_after = fifo_cnt_reg + 2'(push) - 2'(pop);
    assign slot_free      = (fifo_cnt_after < 2'd2);
    assign last_capt      = push && (byte_cnt_reg == LAST_IDX);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_CPU_OWN:
                if (active_reg && slot_free && !cpu_req)
                    state_next = S_DEAD_TO_VID;
            S_DEAD_TO_VID:
                state_next = S_VID_ADDR;
            S_VID_ADDR:
                state_next = (WAIT_CYCLES == 0) ? S_VID_CAPT : S_VID_WAIT;
            S_VID_WAIT:
                if (wait_cnt_reg == WAIT_LAST)
                    state_next = S_VID_CAPT;
            S_VID_CAPT:
                // Chain straight into the next access only if nothing forces a bus handover.
                state_next = (!last_capt && slot_free && !cpu_req) ? S_VID_ADDR : S_DEAD_TO_CPU;
            S_DEAD_TO_CPU:
                state_next = S_CPU_OWN;
            default:
                state_next = S_CPU_OWN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_CPU_OWN;
            active_reg     <= 1'b0;
            byte_cnt_reg   <= '0;
            wait_cnt_reg   <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            frame_done_reg <= last_capt;
            wait_cnt_reg   <= (state_reg == S_VID_WAIT) ? wait_cnt_reg + 1'b1 : '0;
            if (frame_start && !active_reg) begin
                active_reg   <= 1'b1;
                byte_cnt_reg <= '0;
            end else begin
                if (last_capt)
                    active_reg <= 1'b0;
                if (push)
                    byte_cnt_reg <= byte_cnt_reg + 1'b1;
            end
        end
    end

    // Head register drives px_byte directly; tail only holds the second entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg     <= 8'h00;
            tail_reg     <= 8'h00;
            fifo_cnt_reg <= 2'd0;
        end else begin
            fifo_cnt_reg <= fifo_cnt_after;
            case ({push, pop})
                2'b10: begin
                    if (fifo_cnt_reg == 2'd0)
                        head_reg <= sram_data_in;
                    else
                        tail_reg <= sram_data_in;
                end
                2'b01: head_reg <= tail_reg;
                2'b11: begin
                    if (fifo_cnt_reg == 2'd1) begin
                        head_reg <= sram_data_in;
                    end else begin
                        head_reg <= tail_reg;
                        tail_reg <= sram_data_in;
                    end
                end
                default: ;
            endcase
        end
    end

    assign vid_own    = (state_reg == S_VID_ADDR) || (state_reg == S_VID_WAIT) ||
                        (state_reg == S_VID_CAPT);
    assign cpu_gnt    = (state_reg == S_CPU_OWN);
    assign mux_oe1_n  = !cpu_gnt;
    assign mux_oe2_n  = !vid_own;
    assign sram_ce_n  = !vid_own;
    assign sram_oe_n  = !vid_own;
    assign sram_we_n  = 1'b1;
    assign sram_addr  = vid_own ? (BASE_ADDR + ADDR_W'(byte_cnt_reg)) : '0;
    assign px_byte    = head_reg;
    assign px_valid   = (fifo_cnt_reg != 2'd0);
    assign frame_done = frame_done_reg;

endmodule
